// File: rtl/sym_vn_pkg.sv
// Shared types and default sizing for the symmetric VN rank LUT.
package sym_vn_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } vn_state_t;

  localparam int QUAN_SIZE_DEF   = 4;
  localparam int PAGE_ADDR_W_DEF = 6;
endpackage

// File: rtl/sym_vn_lut_mp.sv
// One LUT bank: a single synchronous write port and READ_PORTS combinational read ports.
module sym_vn_lut_mp
  import sym_vn_pkg::*;
#(
  parameter int QUAN_SIZE  = QUAN_SIZE_DEF,
  parameter int ADDR_W     = PAGE_ADDR_W_DEF + 1,
  parameter int READ_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [QUAN_SIZE-1:0]           wdata,
  input  logic [READ_PORTS*ADDR_W-1:0]   raddr,
  output logic [READ_PORTS*QUAN_SIZE-1:0] rdata
);
  logic [QUAN_SIZE-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    assign rdata[p*QUAN_SIZE +: QUAN_SIZE] = mem[raddr[p*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/sym_vn_rank_mb.sv
// Multi-bank, multi-port VN rank LUT; reads serve the active half while a
// reload streams into the shadow half, then an atomic swap promotes it.
module sym_vn_rank_mb
  import sym_vn_pkg::*;
#(
  parameter int QUAN_SIZE   = QUAN_SIZE_DEF,
  parameter int BANK_NUM    = 2,
  parameter int PAGE_ADDR_W = PAGE_ADDR_W_DEF,
  parameter int READ_PORTS  = 2,
  localparam int BANK_W     = $clog2(BANK_NUM)
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic [READ_PORTS-1:0]             rd_en,
  input  logic [READ_PORTS*BANK_W-1:0]      rd_bank,
  input  logic [READ_PORTS*PAGE_ADDR_W-1:0] rd_page,
  output logic [READ_PORTS*QUAN_SIZE-1:0]   lut_data,
  output logic [READ_PORTS-1:0]             lut_valid,
  input  logic                              load_start,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [BANK_NUM*QUAN_SIZE-1:0]     load_data,
  input  logic                              load_last,
  input  logic                              swap_req,
  output logic                              active_sel,
  output logic                              shadow_full,
  output logic                              load_err
);
  localparam int ADDR_W = PAGE_ADDR_W + 1;
  localparam logic [PAGE_ADDR_W-1:0] PTR_MAX = '1;

  vn_state_t                       state, state_nxt;
  logic [PAGE_ADDR_W-1:0]          load_ptr, ptr_nxt;
  logic                            active_nxt, err_nxt, beat;
  logic [READ_PORTS*ADDR_W-1:0]    rd_addr;
  logic [READ_PORTS*QUAN_SIZE-1:0] bank_rdata [BANK_NUM];
  logic [READ_PORTS*QUAN_SIZE-1:0] port_rdata;

  assign load_ready  = (state == LOAD);
  assign shadow_full = (state == FULL);
  assign beat        = load_valid & load_ready;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_addr
    assign rd_addr[p*ADDR_W +: ADDR_W] = {active_sel, rd_page[p*PAGE_ADDR_W +: PAGE_ADDR_W]};
  end

  // Loads always target the inactive half, so reads never see a partial table.
  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    sym_vn_lut_mp #(
      .QUAN_SIZE (QUAN_SIZE),
      .ADDR_W    (ADDR_W),
      .READ_PORTS(READ_PORTS)
    ) u_bank (
      .clk  (write_clk),
      .we   (beat),
      .waddr({~active_sel, load_ptr}),
      .wdata(load_data[b*QUAN_SIZE +: QUAN_SIZE]),
      .raddr(rd_addr),
      .rdata(bank_rdata[b])
    );
  end

  always_comb begin
    port_rdata = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      port_rdata[p*QUAN_SIZE +: QUAN_SIZE] =
        bank_rdata[rd_bank[p*BANK_W +: BANK_W]][p*QUAN_SIZE +: QUAN_SIZE];
    end
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      lut_data  <= '0;
      lut_valid <= '0;
    end else begin
      lut_valid <= rd_en;
      for (int p = 0; p < READ_PORTS; p++) begin
        if (rd_en[p]) lut_data[p*QUAN_SIZE +: QUAN_SIZE] <= port_rdata[p*QUAN_SIZE +: QUAN_SIZE];
      end
    end
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      load_ptr   <= '0;
      active_sel <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      load_ptr   <= ptr_nxt;
      active_sel <= active_nxt;
      load_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = load_ptr;
    active_nxt = active_sel;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req) err_nxt = 1'b1;
        if (load_start) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
        end
      end
      LOAD: begin
        if (swap_req || load_start) err_nxt = 1'b1;
        if (beat) begin
          ptr_nxt = load_ptr + PAGE_ADDR_W'(1);
          if (load_last || load_ptr == PTR_MAX) state_nxt = FULL;
        end
      end
      FULL: begin
        // A restart takes priority over a simultaneous swap.
        if (load_start) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
          err_nxt   = swap_req;
        end else if (swap_req) begin
          active_nxt = ~active_sel;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sym_vn_rank_mb.sv
// Self-checking bench for sym_vn_rank_mb against a table-level reference model.
module tb_sym_vn_rank_mb;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_FULL = 2;

  logic        write_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_en = '0;
  logic [1:0]  rd_bank = '0;
  logic [11:0] rd_page = '0;
  logic [7:0]  lut_data;
  logic [1:0]  lut_valid;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [7:0]  load_data = '0;
  logic        load_last = 1'b0;
  logic        swap_req = 1'b0;
  logic        active_sel;
  logic        shadow_full;
  logic        load_err;

  int errors = 0;
  int checks = 0;

  logic [3:0] mm [2][128];
  bit         mv [2][128];
  int         m_mode;
  int         m_ptr;
  int         m_active;
  logic [3:0] exp_data [2];
  bit         exp_known [2];
  logic [1:0] exp_valid;
  logic       exp_err;

  sym_vn_rank_mb dut (
    .write_clk  (write_clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_bank    (rd_bank),
    .rd_page    (rd_page),
    .lut_data   (lut_data),
    .lut_valid  (lut_valid),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .swap_req   (swap_req),
    .active_sel (active_sel),
    .shadow_full(shadow_full),
    .load_err   (load_err)
  );

  always #5 write_clk = ~write_clk;

  // Advance one clock; the model applies the same edge to its table image.
  task automatic tick();
    int a;
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) begin
        a = m_active * 64 + int'(rd_page[p*6 +: 6]);
        exp_data[p]  = mm[rd_bank[p]][a];
        exp_known[p] = mv[rd_bank[p]][a];
      end
    end
    exp_valid = rd_en;
    exp_err   = 1'b0;
    if (m_mode == M_IDLE) begin
      if (swap_req) exp_err = 1'b1;
      if (load_start) begin m_mode = M_LOAD; m_ptr = 0; end
    end else if (m_mode == M_LOAD) begin
      if (swap_req || load_start) exp_err = 1'b1;
      if (load_valid) begin
        for (int b = 0; b < 2; b++) begin
          mm[b][(1 - m_active) * 64 + m_ptr] = load_data[b*4 +: 4];
          mv[b][(1 - m_active) * 64 + m_ptr] = 1'b1;
        end
        if (load_last || m_ptr == 63) m_mode = M_FULL;
        m_ptr = (m_ptr + 1) % 64;
      end
    end else begin
      if (load_start) begin m_mode = M_LOAD; m_ptr = 0; exp_err = swap_req; end
      else if (swap_req) begin m_active = 1 - m_active; m_mode = M_IDLE; end
    end
    @(posedge write_clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rd_en = '0; load_start = 0; load_valid = 0; load_last = 0; swap_req = 0;
    repeat (2) @(posedge write_clk);
    #1;
    m_mode = M_IDLE; m_ptr = 0; m_active = 0;
    exp_valid = '0; exp_err = 1'b0;
    for (int p = 0; p < 2; p++) begin exp_data[p] = '0; exp_known[p] = 1'b1; end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (lut_data !== 8'h00)  begin errors++; $display("FAIL reset_lut_data got %h want 00", lut_data); end
    checks++; if (lut_valid !== 2'b00) begin errors++; $display("FAIL reset_lut_valid got %b want 00", lut_valid); end
    checks++; if ({load_ready, active_sel, shadow_full, load_err} !== 4'b0000)
      begin errors++; $display("FAIL reset_ctrl got %b want 0000", {load_ready, active_sel, shadow_full, load_err}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_load();
    load_start = 1; tick(); load_start = 0;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", load_ready); end
    for (int pg = 0; pg < 64; pg++) begin
      logic [5:0] pv;
      pv = 6'(pg);
      load_valid = 1; load_data = {~pv[3:0], pv[3:0]};
      tick();
    end
    load_valid = 0;
    checks++; if ({shadow_full, load_ready} !== 2'b10)
      begin errors++; $display("FAIL full_after_wrap got %b want 10", {shadow_full, load_ready}); end
    swap_req = 1; tick(); swap_req = 0;
    checks++; if ({active_sel, shadow_full} !== 2'b10)
      begin errors++; $display("FAIL swap_state got %b want 10", {active_sel, shadow_full}); end
    rd_en = 2'b01; rd_bank = 2'b01; rd_page = 12'd5; tick(); rd_en = 0;
    checks++; if (lut_data[3:0] !== 4'hA) begin errors++; $display("FAIL bank1_page5 got %h want a", lut_data[3:0]); end
    checks++; if (lut_valid !== 2'b01) begin errors++; $display("FAIL valid_p0 got %b want 01", lut_valid); end
  endtask

  task automatic test_same_page();
    rd_en = 2'b11; rd_bank = 2'b00; rd_page = {6'd63, 6'd63}; tick(); rd_en = 0;
    checks++; if (lut_data !== 8'hFF) begin errors++; $display("FAIL same_page got %h want ff", lut_data); end
    checks++; if (lut_valid !== 2'b11) begin errors++; $display("FAIL same_valid got %b want 11", lut_valid); end
    tick();
    checks++; if (lut_valid !== 2'b00 || lut_data !== 8'hFF)
      begin errors++; $display("FAIL hold got %b/%h want 00/ff", lut_valid, lut_data); end
  endtask

  task automatic test_reads_during_load();
    int cyc = 0;
    load_start = 1; tick(); load_start = 0;
    while (m_mode != M_FULL && cyc < 500) begin
      load_valid = ($urandom_range(0, 3) != 0); load_data = 8'($urandom);
      rd_en = 2'($urandom); rd_bank = 2'($urandom); rd_page = 12'($urandom);
      tick();
      cyc++;
      checks++; if (lut_valid !== exp_valid) begin errors++; $display("FAIL dl_valid got %b want %b", lut_valid, exp_valid); end
      for (int p = 0; p < 2; p++) if (exp_known[p]) begin
        checks++; if (lut_data[p*4 +: 4] !== exp_data[p])
          begin errors++; $display("FAIL dl_data p%0d got %h want %h", p, lut_data[p*4 +: 4], exp_data[p]); end
      end
    end
    load_valid = 0;
    checks++; if (shadow_full !== 1'b1 || m_mode != M_FULL)
      begin errors++; $display("FAIL dl_reach_full got %b want 1 (cycles %0d)", shadow_full, cyc); end
    rd_en = 2'b11; rd_bank = 2'b00; rd_page = {6'd7, 6'd7};
    swap_req = 1; tick(); swap_req = 0;
    checks++; if (lut_data[3:0] !== 4'h7) begin errors++; $display("FAIL swap_edge_old got %h want 7", lut_data[3:0]); end
    tick(); rd_en = 0;
    checks++; if (lut_data[3:0] !== exp_data[0] || active_sel !== 1'b0)
      begin errors++; $display("FAIL swap_next_new got %h/%b want %h/0", lut_data[3:0], active_sel, exp_data[0]); end
  endtask

  task automatic test_early_last();
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1; load_data = 8'($urandom); load_last = (i == 9);
      tick();
    end
    load_valid = 0; load_last = 0;
    checks++; if (shadow_full !== 1'b1 || dut.load_ptr !== 6'd10)
      begin errors++; $display("FAIL early_full got %b/%0d want 1/10", shadow_full, dut.load_ptr); end
    swap_req = 1; tick(); swap_req = 0;
    rd_en = 2'b11; rd_bank = 2'b10; rd_page = {6'd9, 6'd10}; tick();
    checks++; if (lut_data[3:0] !== 4'hA) begin errors++; $display("FAIL early_page10_old got %h want a", lut_data[3:0]); end
    checks++; if (lut_data[7:4] !== exp_data[1])
      begin errors++; $display("FAIL early_page9_new got %h want %h", lut_data[7:4], exp_data[1]); end
    for (int pg = 0; pg < 16; pg++) begin
      rd_bank = 2'b10; rd_page = {6'(pg), 6'(pg)}; tick();
      for (int p = 0; p < 2; p++) begin
        checks++; if (lut_data[p*4 +: 4] !== exp_data[p] || !exp_known[p])
          begin errors++; $display("FAIL early_scan pg%0d p%0d got %h want %h", pg, p, lut_data[p*4 +: 4], exp_data[p]); end
      end
    end
    rd_en = 0;
  endtask

  task automatic test_illegal();
    swap_req = 1; tick(); swap_req = 0;
    checks++; if (load_err !== 1'b1 || active_sel !== 1'b1)
      begin errors++; $display("FAIL swap_idle_err got %b/%b want 1/1", load_err, active_sel); end
    tick();
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b want 0", load_err); end
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 3; i++) begin load_valid = 1; load_data = 8'($urandom); tick(); end
    load_valid = 0;
    load_start = 1; tick(); load_start = 0;
    checks++; if ({load_err, load_ready, active_sel} !== 3'b111 || dut.load_ptr !== 6'd3)
      begin errors++; $display("FAIL start_in_load got %b/%0d want 111/3", {load_err, load_ready, active_sel}, dut.load_ptr); end
    tick();
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", load_err); end
    load_valid = 1; load_last = 1; load_data = 8'($urandom); tick();
    load_valid = 0; load_last = 0;
    load_start = 1; swap_req = 1; tick(); load_start = 0; swap_req = 0;
    checks++; if ({load_err, load_ready, active_sel} !== 3'b111)
      begin errors++; $display("FAIL start_beats_swap got %b want 111", {load_err, load_ready, active_sel}); end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 30; i++) begin load_valid = 1; load_data = 8'($urandom); tick(); end
    load_data = 8'($urandom);
    apply_reset();
    checks++; if ({lut_data, lut_valid} !== 10'd0)
      begin errors++; $display("FAIL rst_mid_data got %h/%b want 00/00", lut_data, lut_valid); end
    checks++; if ({load_ready, active_sel, shadow_full, load_err} !== 4'b0000 || dut.state !== sym_vn_pkg::IDLE)
      begin errors++; $display("FAIL rst_mid_ctrl got %b want 0000", {load_ready, active_sel, shadow_full, load_err}); end
    rst = 1'b0; tick();
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 64; i++) begin load_valid = 1; load_data = 8'($urandom); tick(); end
    load_valid = 0;
    checks++; if (shadow_full !== 1'b1) begin errors++; $display("FAIL reload_full got %b want 1", shadow_full); end
    swap_req = 1; tick(); swap_req = 0;
    for (int i = 0; i < 40; i++) begin
      rd_en = 2'($urandom); rd_bank = 2'($urandom); rd_page = 12'($urandom);
      tick();
      for (int p = 0; p < 2; p++) if (rd_en[p]) begin
        checks++; if (lut_data[p*4 +: 4] !== exp_data[p] || !exp_known[p])
          begin errors++; $display("FAIL reload_read p%0d got %h want %h", p, lut_data[p*4 +: 4], exp_data[p]); end
      end
    end
    rd_en = 0;
    checks++; if (active_sel !== 1'b1) begin errors++; $display("FAIL reload_active got %b want 1", active_sel); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int b = 0; b < 2; b++) for (int a = 0; a < 128; a++) begin mm[b][a] = 'x; mv[b][a] = 1'b0; end
    test_reset();
    test_full_load();
    test_same_page();
    test_reads_during_load();
    test_early_last();
    test_illegal();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sym_vn_rank_mb.md
# sym_vn_rank_mb

Parametrised multi-bank, multi-port symmetric VN rank LUT with an on-block double-buffered reload engine. Serves N read ports from BANK_NUM banks of QUAN_SIZE-bit entries each cycle. While the read ports use the active half of each bank, a new table streams into the shadow half, and an atomic swap then makes it active. Sits between the LUT-update path from the host/loader and the partial VNU array of the layer decoder.

## Interface
- QUAN_SIZE, 4, LUT entry width in bits.
- BANK_NUM, 2, number of banks; power of two, at least 2.
- PAGE_ADDR_W, 6, page address width; each half holds 2^PAGE_ADDR_W entries per bank.
- READ_PORTS, 2, number of independent VNU read ports.
- BANK_W, clog2(BANK_NUM), derived, not overridable.

Ports:
- write_clk  in  1  the single clock.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  READ_PORTS  per-port read request.
- rd_bank  in  READ_PORTS*BANK_W  per-port bank select; port p occupies slice p.
- rd_page  in  READ_PORTS*PAGE_ADDR_W  per-port page address.
- lut_data  out  READ_PORTS*QUAN_SIZE  registered read data.
- lut_valid  out  READ_PORTS  high one cycle after the matching rd_en.
- load_start  in  1  pulse that begins a shadow reload.
- load_valid  in  1  load beat valid.
- load_ready  out  1  engine accepts beats.
- load_data  in  BANK_NUM*QUAN_SIZE  one entry per bank for the current page.
- load_last  in  1  marks the final beat.
- swap_req  in  1  request to promote the shadow half to active.
- active_sel  out  1  half currently served to the read ports.
- shadow_full  out  1  shadow load complete, swap allowed.
- load_err  out  1  one-cycle pulse on an illegal request.

## Operation
- Storage per bank is 2*2^PAGE_ADDR_W entries. Address = {half, page}. Reads use half = active_sel. Loads write half = ~active_sel.
- Read port p: on rd_en[p], the block registers bank rd_bank[p] at address {active_sel, rd_page[p]} into lut_data[p]. When rd_en is low, lut_data holds its value. Ports are fully independent, and any number of ports may hit the same bank or page.
- FSM states:
  - IDLE: load_ready=0. load_start goes to LOAD and clears load_ptr and shadow_full.
  - LOAD: load_ready=1. Each beat (load_valid & load_ready) writes load_data slice b to bank b at {~active_sel, load_ptr}, then increments load_ptr. The block goes to FULL on load_last, or on a beat at load_ptr = 2^PAGE_ADDR_W-1 (the pointer then wraps to 0). Entries beyond an early load_last keep their old contents.
  - FULL: shadow_full=1, load_ready=0. swap_req toggles active_sel and goes to IDLE. load_start restarts LOAD, discarding the shadow.
- Illegal requests pulse load_err and change no state:
  - swap_req in IDLE or LOAD.
  - load_start in LOAD.

## Timing
- Reset values: lut_data=0, lut_valid=0, load_ready=0, active_sel=0, shadow_full=0, load_err=0, FSM=IDLE, load_ptr=0. Memory contents are not reset.
- Read latency is exactly 1 cycle.
- Write takes effect on the beat edge. Shadow writes never alias active reads, so there are no read/write hazards.
- Swap is accepted on edge T:
  - reads sampled at edge T use the old active_sel;
  - reads sampled at T+1 and later use the new active_sel.
- shadow_full rises on the cycle after the final beat and falls on the cycle after the swap.
- load_start and swap_req in the same cycle in FULL: load_start wins, the swap is dropped and load_err pulses.
- Reset asserted mid-LOAD aborts the load and returns active_sel to 0. The table served after reset is whatever half 0 holds.

## Structure
- Shared package sym_vn_pkg holds:
  - the FSM state enum (IDLE, LOAD, FULL);
  - default QUAN_SIZE and PAGE_ADDR_W.
- One sub-module, sym_vn_lut_mp: a single bank with one write port and READ_PORTS asynchronous read ports, QUAN_SIZE x 2^(PAGE_ADDR_W+1). It is instantiated BANK_NUM times via generate.
- Per-port bank muxes, output registers and the FSM live in the top level.

## Test plan
- Reset, then load pages 0..63 with bank0 = page[3:0] and bank1 = ~page[3:0], then swap. After that, port0 reads bank1 page 5 -> lut_data[3:0]=4'hA one cycle later. active_sel=1.
- Both ports read the same bank and page (bank0, page 63) in the same cycle -> both return 4'hF with lut_valid=2'b11.
- Reads run every cycle during a second full load -> data is still the first table, unchanged until the swap edge; the first read after the swap returns the new value.
- load_last on the 10th beat -> FULL with load_ptr=10. After the swap, page 9 holds new data and page 10 holds the previous shadow data.
- swap_req in IDLE, and load_start during LOAD -> load_err pulses one cycle; active_sel and load_ptr are unchanged.
- Assert rst at beat 30 of a load -> all outputs are at reset values, the FSM is in IDLE, and a following load_start loads normally.
